// File: rtl/mod_seq_pkg.sv
// Shared definitions for the modulo phase sequencer.
//   state_e  : controller state encoding
//   DEF_MOD  : reset value of every modulus table entry
//   phase_w  : width of a phase index for a given phase count
package mod_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_MOD = 9;

  function automatic int unsigned phase_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_cnt.sv
// WIDTH-bit up counter with synchronous clear and enable.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment enable
//   limit      : compare value
//   count      : current count
//   hit        : count == limit
module mod_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign hit   = (count_q == limit);

endmodule

// File: rtl/mod_seq_ctrl.sv
// Programmable phase sequencer: steps a shared modulo counter through
// NPHASE phases, each of length mod[p]+1 cycles, then pulses done.
//   clk, reset : clock, asynchronous active-low reset
//   start      : begin a sequence (sampled in IDLE only)
//   abort      : synchronous stop of a running sequence
//   mod_wr     : modulus table write strobe (ignored while busy)
//   mod_addr   : table entry to write
//   mod_data   : modulus value M (phase counts 0..M)
//   busy       : sequence running
//   phase      : current phase index
//   count      : current count value
//   tc         : terminal count of the current phase
//   done       : one-cycle pulse on sequence completion
module mod_seq_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NPHASE  = 4,
  parameter int unsigned DEF_MOD = mod_seq_pkg::DEF_MOD
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   mod_wr,
  input  logic [mod_seq_pkg::phase_w(NPHASE)-1:0] mod_addr,
  input  logic [WIDTH-1:0]                       mod_data,
  output logic                                   busy,
  output logic [mod_seq_pkg::phase_w(NPHASE)-1:0] phase,
  output logic [WIDTH-1:0]                       count,
  output logic                                   tc,
  output logic                                   done
);

  import mod_seq_pkg::*;

  localparam int unsigned PW = phase_w(NPHASE);

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mod_q [NPHASE];
  logic [WIDTH-1:0] mod_d [NPHASE];

  logic             cnt_clr, cnt_en, cnt_hit;
  logic [WIDTH-1:0] cnt_val;
  logic [WIDTH-1:0] cur_mod;
  logic             last_phase;

  assign cur_mod    = mod_q[phase_q];
  assign last_phase = (phase_q == PW'(NPHASE - 1));

  mod_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cur_mod),
    .count (cnt_val),
    .hit   (cnt_hit)
  );

  // Modulus table: writable only while no sequence is running.
  always_comb begin
    for (int unsigned i = 0; i < NPHASE; i++) begin
      mod_d[i] = mod_q[i];
    end
    if (mod_wr && !busy_q) begin
      mod_d[mod_addr] = mod_data;
    end
  end

  // Next-state / registered-output logic.
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        phase_d = phase_q;
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (cnt_hit) begin
          if (last_phase) begin
            state_d = ST_DONE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NPHASE; i++) begin
        mod_q[i] <= WIDTH'(DEF_MOD);
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < NPHASE; i++) begin
        mod_q[i] <= mod_d[i];
      end
    end
  end

  // Counter control and terminal-count decode. Outside RUN the counter is
  // held clear; in RUN a hit or abort returns it to zero for the next cycle.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    tc      = 1'b0;
    if (state_q == ST_RUN) begin
      tc      = cnt_hit;
      cnt_clr = abort || cnt_hit;
      cnt_en  = !cnt_clr;
    end
  end

  assign busy  = busy_q;
  assign phase = phase_q;
  assign count = cnt_val;
  assign done  = done_q;

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Self-checking bench for mod_seq_ctrl: directed scenarios plus random
// stimulus, checked against a queue-based reference model that expands the
// modulus table into the full list of expected (phase, count, tc) cycles.
module tb_mod_seq_ctrl;

  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, mod_wr;
  logic [1:0] mod_addr;
  logic [3:0] mod_data;
  logic       busy;
  logic [1:0] phase;
  logic [3:0] count;
  logic       tc, done;

  always #5 clk = ~clk;

  mod_seq_ctrl #(
    .WIDTH   (4),
    .NPHASE  (4),
    .DEF_MOD (9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mod_wr   (mod_wr),
    .mod_addr (mod_addr),
    .mod_data (mod_data),
    .busy     (busy),
    .phase    (phase),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  typedef struct {
    int ph;
    int cnt;
    int tcv;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   tab [NP];
  bit   m_run, m_done;
  exp_t q [$];
  int   n_busy, n_tc, n_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) tab[i] = 9;
    m_run  = 1'b0;
    m_done = 1'b0;
    q.delete();
  endfunction

  function automatic void clear_counts();
    n_busy = 0;
    n_tc   = 0;
    n_done = 0;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    if (m_run) e = q[0];
    else e = '{0, 0, 0};
    check("busy",  32'(busy),  32'(m_run));
    check("phase", 32'(phase), 32'(e.ph));
    check("count", 32'(count), 32'(e.cnt));
    check("tc",    32'(tc),    32'(e.tcv));
    check("done",  32'(done),  32'(m_done));
    n_busy += int'(busy);
    n_tc   += int'(tc);
    n_done += int'(done);
  endtask

  task automatic step(input bit s, input bit a, input bit w, input int addr, input int data);
    start    = s;
    abort    = a;
    mod_wr   = w;
    mod_addr = 2'(addr);
    mod_data = 4'(data);
    @(posedge clk);
    cyc++;
    if (!m_run && w) tab[addr & 3] = data & 15;
    if (m_run) begin
      if (a) begin
        m_run = 1'b0;
        q.delete();
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (s && !a) begin
      for (int p = 0; p < NP; p++)
        for (int c = 0; c <= tab[p]; c++)
          q.push_back('{p, c, (c == tab[p]) ? 1 : 0});
      m_run = 1'b1;
    end
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    start = 1'b0; abort = 1'b0; mod_wr = 1'b0; mod_addr = '0; mod_data = '0;
    model_reset();
    clear_counts();
    #12;
    compare_outputs();
    reset = 1'b1;
    #10;

    // Reset-default table: 4 phases of 10 cycles.
    clear_counts();
    step(1, 0, 0, 0, 0);
    idle(44);
    check("def_busy_cycles", 32'(n_busy), 32'd40);
    check("def_tc_cycles",   32'(n_tc),   32'd4);
    check("def_done_pulses", 32'(n_done), 32'd1);

    // Programmed table {2,0,5,1}.
    step(0, 0, 1, 0, 2);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 2, 5);
    step(0, 0, 1, 3, 1);
    clear_counts();
    step(1, 0, 0, 0, 0);
    idle(15);
    check("prog_busy_cycles", 32'(n_busy), 32'd12);
    check("prog_tc_cycles",   32'(n_tc),   32'd4);
    check("prog_done_pulses", 32'(n_done), 32'd1);

    // Abort in phase 1 at count 4.
    for (int i = 0; i < NP; i++) step(0, 0, 1, i, 9);
    clear_counts();
    step(1, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() > 0 && q[0].ph == 1 && q[0].cnt == 4) begin
        found = 1'b1;
        break;
      end
      step(0, 0, 0, 0, 0);
    end
    check("wait_abort_point", 32'(found), 32'd1);
    step(0, 1, 0, 0, 0);
    check("abort_busy", 32'(busy), 32'd0);
    idle(3);
    check("abort_no_done", 32'(n_done), 32'd0);
    clear_counts();
    step(1, 0, 0, 0, 0);
    idle(44);
    check("rerun_busy_cycles", 32'(n_busy), 32'd40);
    check("rerun_done_pulses", 32'(n_done), 32'd1);

    // Write while busy is ignored; retried in IDLE it takes effect.
    clear_counts();
    step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 1, 3, 1);
    idle(40);
    check("busy_wr_ignored_cycles", 32'(n_busy), 32'd40);
    step(0, 0, 1, 3, 1);
    clear_counts();
    step(1, 0, 0, 0, 0);
    idle(40);
    check("idle_wr_applied_cycles", 32'(n_busy), 32'd32);

    // Asynchronous reset in phase 2, then table must be back to all 9s.
    step(1, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() > 0 && q[0].ph == 2) begin
        found = 1'b1;
        break;
      end
      step(0, 0, 0, 0, 0);
    end
    check("wait_phase2", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    #3 reset = 1'b1;
    clear_counts();
    step(1, 0, 0, 0, 0);
    idle(44);
    check("post_reset_busy_cycles", 32'(n_busy), 32'd40);

    // start with abort in IDLE stays idle.
    step(1, 1, 0, 0, 0);
    check("start_abort_idle", 32'(busy), 32'd0);
    idle(2);

    // start during DONE is ignored.
    clear_counts();
    step(1, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_done) begin
        found = 1'b1;
        break;
      end
      step(0, 0, 0, 0, 0);
    end
    check("wait_done", 32'(found), 32'd1);
    step(1, 0, 0, 0, 0);
    idle(3);
    check("done_start_ignored", 32'(n_busy), 32'd40);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
